// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 8-entry register file and its 2-port arbiter.
package regfile_pkg;

    localparam int DATA_W    = 5;
    localparam int ADDR_W    = 3;
    localparam int NUM_REGS  = 2 ** ADDR_W;
    localparam int NUM_PORTS = 2;

    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        reg_data_t wdata;
    } req_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way grant logic for the register file ports.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module rr_arb2
    import regfile_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic                 clk,
    input  logic                 rst,
`endif
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 busy
);

    assign busy = &req_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // Resets to port 1 so that port 0 wins the first contention.
    logic last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[PORT_DBG];
        end
    end

    always_comb begin
        grant = '0;
        if (busy) begin
            grant[PORT_CORE] = last_grant;
            grant[PORT_DBG]  = ~last_grant;
        end else begin
            grant = req_valid;
        end
    end
`else
    always_comb begin
        grant            = '0;
        grant[PORT_CORE] = req_valid[PORT_CORE];
        grant[PORT_DBG]  = req_valid[PORT_DBG] & ~req_valid[PORT_CORE];
    end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// 8-entry register file shared by the core port (0) and the debug port (1).
// Arbitration mode follows ARB_ROUND_ROBIN_EN (see rr_arb2).
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter reg_data_t RESET_R0 = reg_data_t'(1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          busy
);

    req_t                 req [NUM_PORTS];
    req_t                 gsel;
    logic [NUM_PORTS-1:0] grant;
    logic                 xfer;
    reg_data_t            regs [NUM_REGS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req[p].we    = req_we[p];
            req[p].addr  = req_addr[p*ADDR_W +: ADDR_W];
            req[p].wdata = req_wdata[p*DATA_W +: DATA_W];
        end
    end

    rr_arb2 u_arb (
`ifdef ARB_ROUND_ROBIN_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .req_valid (req_valid),
        .grant     (grant),
        .busy      (busy)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign gsel      = req[grant[PORT_DBG]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0) ? RESET_R0 : '0;
            end
        end else if (xfer && gsel.we) begin
            regs[gsel.addr] <= gsel.wdata;
        end
    end

    // rsp_rdata only moves on a read transfer, so it holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= grant & {NUM_PORTS{~gsel.we}};
            if (xfer && !gsel.we) begin
                rsp_rdata <= regs[gsel.addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter (either arbitration mode).
module tb_regfile_arbiter;
    import regfile_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_PORTS-1:0]        req_valid = '0;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        req_we = '0;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr = '0;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata = '0;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        busy;

    int errors = 0;
    int checks = 0;

    regfile_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[p]               = v;
        req_we[p]                  = we;
        req_addr[p*ADDR_W +: ADDR_W] = a;
        req_wdata[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_port(0, 1'b1, 1'b0, 3'd0, 5'd0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_rd0_ready got=%b exp=01", req_ready); end
        step();
        set_port(0, 1'b1, 1'b0, 3'd7, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'd1) begin
            errors++; $display("FAIL reset_r0 got v=%b d=%h exp v=01 d=01", rsp_valid, rsp_rdata);
        end
        step();
        set_port(0, 1'b1, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'd0) begin
            errors++; $display("FAIL reset_r7 got v=%b d=%h exp v=01 d=00", rsp_valid, rsp_rdata);
        end
        step();
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        // response for r0 is showing now; reset mid-cycle must clear it at once
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 5'd0) begin
            errors++; $display("FAIL reset_async got v=%b d=%h exp v=00 d=00", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_port();
        set_port(0, 1'b1, 1'b1, 3'd3, 5'h15);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_wr_ready got=%b exp=01", req_ready); end
        step();
        set_port(0, 1'b1, 1'b0, 3'd3, 5'd0);
        #1;
        checks++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL single_rd_ready got rdy=%b v=%b exp rdy=01 v=00", req_ready, rsp_valid);
        end
        step();
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'h15) begin
            errors++; $display("FAIL single_rd got v=%b d=%h exp v=01 d=15", rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 5'h15) begin
            errors++; $display("FAIL single_pulse_hold got v=%b d=%h exp v=00 d=15", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        set_port(0, 1'b1, 1'b1, 3'd1, 5'h03);
        step();
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        set_port(1, 1'b1, 1'b1, 3'd2, 5'h1C);
        step();
        // last transfer was port 1, so port 0 wins the first contention in both modes
        set_port(0, 1'b1, 1'b0, 3'd1, 5'd0);
        set_port(1, 1'b1, 1'b0, 3'd2, 5'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready !== exp_g[i] || busy !== 1'b1) begin
                errors++; $display("FAIL contend_grant[%0d] got rdy=%b busy=%b exp rdy=%b busy=1", i, req_ready, busy, exp_g[i]);
            end
            step();
            checks++;
            if (rsp_valid !== exp_g[i] || rsp_rdata !== ((exp_g[i] == 2'b01) ? 5'h03 : 5'h1C)) begin
                errors++; $display("FAIL contend_rsp[%0d] got v=%b d=%h exp v=%b", i, rsp_valid, rsp_rdata, exp_g[i]);
            end
        end
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        #1;
        checks++;
        if (req_ready !== 2'b10 || busy !== 1'b0) begin
            errors++; $display("FAIL contend_drop0 got rdy=%b busy=%b exp rdy=10 busy=0", req_ready, busy);
        end
        step();
        set_port(1, 1'b0, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 5'h1C) begin
            errors++; $display("FAIL contend_p1_rsp got v=%b d=%h exp v=10 d=1c", rsp_valid, rsp_rdata);
        end
        step();
    endtask

    task automatic test_hold_under_stall();
        // last grant was port 1, so port 0 wins this contention in both modes
        set_port(1, 1'b1, 1'b1, 3'd5, 5'h0A);
        set_port(0, 1'b1, 1'b0, 3'd5, 5'd0);
        #1;
        checks++;
        if (req_ready !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL stall_ready got rdy=%b busy=%b exp rdy=01 busy=1", req_ready, busy);
        end
        step();
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'h00) begin
            errors++; $display("FAIL stall_r5_unchanged got v=%b d=%h exp v=01 d=00", rsp_valid, rsp_rdata);
        end
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release got=%b exp=10", req_ready); end
        step();
        set_port(1, 1'b0, 1'b0, 3'd0, 5'd0);
        set_port(0, 1'b1, 1'b0, 3'd5, 5'd0);
        step();
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'h0A) begin
            errors++; $display("FAIL stall_r5_read got v=%b d=%h exp v=01 d=0a", rsp_valid, rsp_rdata);
        end
        step();
    endtask

    task automatic test_raw_cross_port();
        set_port(1, 1'b1, 1'b1, 3'd4, 5'h1F);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL raw_wr_ready got=%b exp=10", req_ready); end
        step();
        set_port(1, 1'b0, 1'b0, 3'd0, 5'd0);
        set_port(0, 1'b1, 1'b0, 3'd4, 5'd0);
        step();
        set_port(0, 1'b1, 1'b0, 3'd5, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'h1F) begin
            errors++; $display("FAIL raw_r4 got v=%b d=%h exp v=01 d=1f", rsp_valid, rsp_rdata);
        end
        step();
        set_port(0, 1'b1, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'h0A) begin
            errors++; $display("FAIL raw_r5_intact got v=%b d=%h exp v=01 d=0a", rsp_valid, rsp_rdata);
        end
        step();
        set_port(0, 1'b0, 1'b0, 3'd0, 5'd0);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 5'h01) begin
            errors++; $display("FAIL raw_r0_intact got v=%b d=%h exp v=01 d=01", rsp_valid, rsp_rdata);
        end
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_state got v=%b d=%h busy=%b exp 00/00/0", rsp_valid, rsp_rdata, busy);
        end
        rst = 1'b0;
        step();
        test_reset();
        test_single_port();
        test_contention();
        test_hold_under_stall();
        test_raw_cross_port();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
